// File: rtl/dm_access_pkg.sv
// Shared encodings for the MEM-stage access sequencer: operand widths, FSM states
// and the alignment rule applied to new requests.
package dm_access_pkg;

   typedef enum logic [1:0] {
      OPW_WORD = 2'b00,
      OPW_HALF = 2'b01,
      OPW_BYTE = 2'b10,
      OPW_ILL  = 2'b11
   } op_width_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   // A store with no enabled byte lane is rejected like a misaligned access.
   function automatic logic misaligned(input logic       we,
                                       input op_width_e  width,
                                       input logic [1:0] addr_lo,
                                       input logic [3:0] be);
      logic bad;
      case (width)
         OPW_WORD: bad = (addr_lo != 2'b00);
         OPW_HALF: bad = addr_lo[0];
         OPW_BYTE: bad = 1'b0;
         default:  bad = 1'b1;
      endcase
      return bad | (we & (be == 4'b0000));
   endfunction

endpackage

// File: rtl/dm_access_if.sv
// Pipeline-side request signals and data-memory port of the access sequencer.
// The sequencer uses the slave modport; the surrounding pipeline/memory uses master.
interface dm_access_if;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  op_width;
   logic        load_unsigned;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        stall;
   logic        done;
   logic [31:0] rdata;
   logic        exc_adel;
   logic        exc_ades;
   logic        bus_err;
   logic        mem_req;
   logic        mem_we;
   logic [29:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport slave (
      input  req_valid, req_we, op_width, load_unsigned, addr, be, wdata,
      input  mem_rdata, mem_ready,
      output stall, done, rdata, exc_adel, exc_ades, bus_err,
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );

   modport master (
      output req_valid, req_we, op_width, load_unsigned, addr, be, wdata,
      output mem_rdata, mem_ready,
      input  stall, done, rdata, exc_adel, exc_ades, bus_err,
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/dm_access_load_ext.sv
// Selects the byte/half lane of a read word and sign- or zero-extends it to 32 bits.
module dm_access_load_ext
   import dm_access_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  off_i,
   input  op_width_e   width_i,
   input  logic        unsigned_i,
   output logic [31:0] ext_o
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      case (off_i)
         2'd0: byte_sel = word_i[7:0];
         2'd1: byte_sel = word_i[15:8];
         2'd2: byte_sel = word_i[23:16];
         2'd3: byte_sel = word_i[31:24];
         default: byte_sel = 8'h00;
      endcase
      half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

      ext_o = word_i;
      case (width_i)
         OPW_BYTE: ext_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
         OPW_HALF: ext_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
         default:  ext_o = word_i;
      endcase
   end
endmodule

// File: rtl/dm_access.sv
// MEM-stage access sequencer: one outstanding request to a variable-latency slave,
// with alignment checking, a timeout watchdog and load-data extension.
//
// state | meaning
// IDLE  | waiting for an aligned request from the MEM stage
// BUSY  | mem_req asserted, waiting for mem_ready or timeout
// RESP  | one-cycle done pulse, pipeline released
module dm_access
   import dm_access_pkg::*;
#(
   parameter int unsigned TIMEOUT = 256,
   parameter int unsigned CNT_W   = 16
) (
   input logic        clk,
   input logic        reset,
   dm_access_if.slave bus
);
   state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic        err_q, err_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] rdata_q, rdata_d;
   logic [29:0] mem_addr_q;
   logic [3:0]  mem_be_q;
   logic [31:0] mem_wdata_q;
   logic        we_q;
   op_width_e   width_q;
   logic        uns_q;
   logic [1:0]  off_q;

   op_width_e   req_width;
   logic        req_bad;
   logic        accept;
   logic [31:0] ext_data;

   assign req_width = op_width_e'(bus.op_width);
   assign req_bad   = misaligned(bus.req_we, req_width, bus.addr[1:0], bus.be);
   assign accept    = (state_q == ST_IDLE) && bus.req_valid && !req_bad;

   dm_access_load_ext u_load_ext (
      .word_i     (bus.mem_rdata),
      .off_i      (off_q),
      .width_i    (width_q),
      .unsigned_i (uns_q),
      .ext_o      (ext_data)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      mem_req_d = mem_req_q;
      mem_we_d  = mem_we_q;
      rdata_d   = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d   = ST_BUSY;
               cnt_d     = '0;
               err_d     = 1'b0;
               mem_req_d = 1'b1;
               mem_we_d  = bus.req_we;
            end
         end
         ST_BUSY: begin
            if (bus.mem_ready) begin
               state_d   = ST_RESP;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               rdata_d   = we_q ? 32'h0 : ext_data;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d   = ST_RESP;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               err_d     = 1'b1;
               rdata_d   = 32'h0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         mem_req_q <= 1'b0;
         mem_we_q  <= 1'b0;
         rdata_q   <= 32'h0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         mem_req_q <= mem_req_d;
         mem_we_q  <= mem_we_d;
         rdata_q   <= rdata_d;
      end
   end

   // Request attributes stay frozen for the whole access, independent of the pipeline.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_addr_q  <= 30'h0;
         mem_be_q    <= 4'h0;
         mem_wdata_q <= 32'h0;
         we_q        <= 1'b0;
         width_q     <= OPW_WORD;
         uns_q       <= 1'b0;
         off_q       <= 2'b00;
      end else if (accept) begin
         mem_addr_q  <= bus.addr[31:2];
         mem_be_q    <= bus.req_we ? bus.be : 4'b1111;
         mem_wdata_q <= bus.wdata;
         we_q        <= bus.req_we;
         width_q     <= req_width;
         uns_q       <= bus.load_unsigned;
         off_q       <= bus.addr[1:0];
      end
   end

   // Gating with reset keeps the pipeline-facing outputs at 0 while reset is held.
   assign bus.stall     = !reset && (accept || (state_q == ST_BUSY));
   assign bus.exc_adel  = !reset && (state_q == ST_IDLE) && bus.req_valid && req_bad && !bus.req_we;
   assign bus.exc_ades  = !reset && (state_q == ST_IDLE) && bus.req_valid && req_bad &&  bus.req_we;
   assign bus.done      = (state_q == ST_RESP);
   assign bus.bus_err   = (state_q == ST_RESP) && err_q;
   assign bus.rdata     = rdata_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_be    = mem_be_q;
   assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_dm_access.sv
// Directed bench for dm_access: stimulus pushes expected responses, a monitor
// pops and compares them on every done pulse.
module tb_dm_access;
   localparam int TMO = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t exp_q[$];

   dm_access_if bus ();

   dm_access #(.TIMEOUT(TMO), .CNT_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      #2;
      if (bus.done === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no response");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rdata", bus.rdata, e.rdata);
            chk("bus_err", {31'h0, bus.bus_err}, {31'h0, e.err});
         end
      end
   end

   // Drives one request right after a negedge and tracks it to its done pulse.
   task automatic access(input string nm, input logic we, input logic [1:0] w,
                         input logic uns, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] wd, input logic [31:0] rd, input int waits,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input int exp_stall, input int exp_req);
      int  stalls;
      int  reqs;
      bit  seen;
      exp_t e;
      bus.req_valid = 1'b1;
      bus.req_we = we;
      bus.op_width = w;
      bus.load_unsigned = uns;
      bus.addr = a;
      bus.be = b;
      bus.wdata = wd;
      bus.mem_rdata = rd;
      e.rdata = exp_rd;
      e.err = exp_err;
      exp_q.push_back(e);
      stalls = 0;
      reqs = 0;
      seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         #1;
         if (bus.stall) stalls++;
         if (bus.mem_req) begin
            reqs++;
            if (reqs == 1) begin
               chk({nm, "_mem_addr"}, {2'b00, bus.mem_addr}, {2'b00, a[31:2]});
               chk({nm, "_mem_be"}, {28'h0, bus.mem_be}, {28'h0, (we ? b : 4'hF)});
               chk({nm, "_mem_we"}, {31'h0, bus.mem_we}, {31'h0, we});
               if (we) chk({nm, "_mem_wdata"}, bus.mem_wdata, wd);
            end else if (bus.mem_we !== we || bus.mem_addr !== a[31:2]) begin
               chk({nm, "_held"}, {31'h0, bus.mem_we}, {31'h0, we});
            end
         end
         bus.mem_ready = bus.mem_req && (waits >= 0) && (reqs == waits + 1);
         if (bus.done) begin
            seen = 1;
            bus.req_valid = 1'b0;
         end
         @(negedge clk);
      end
      bus.mem_ready = 1'b0;
      bus.req_valid = 1'b0;
      chk({nm, "_done_seen"}, {31'h0, seen}, 32'h1);
      chk({nm, "_stall_cycles"}, stalls, exp_stall);
      chk({nm, "_req_cycles"}, reqs, exp_req);
   endtask

   task automatic bad_access(input string nm, input logic we, input logic [1:0] w,
                             input logic [31:0] a, input logic [3:0] b);
      bus.req_valid = 1'b1;
      bus.req_we = we;
      bus.op_width = w;
      bus.addr = a;
      bus.be = b;
      #1;
      chk({nm, "_adel"}, {31'h0, bus.exc_adel}, {31'h0, ~we});
      chk({nm, "_ades"}, {31'h0, bus.exc_ades}, {31'h0, we});
      chk({nm, "_stall"}, {31'h0, bus.stall}, 32'h0);
      @(negedge clk);
      #1;
      chk({nm, "_no_req"}, {31'h0, bus.mem_req}, 32'h0);
      bus.req_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_we = 1'b0;
      bus.op_width = 2'b00;
      bus.load_unsigned = 1'b0;
      bus.addr = 32'h0;
      bus.be = 4'h0;
      bus.wdata = 32'h0;
      bus.mem_rdata = 32'h0;
      bus.mem_ready = 1'b0;
      #12;
      chk("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
      chk("rst_done", {31'h0, bus.done}, 32'h0);
      chk("rst_rdata", bus.rdata, 32'h0);
      chk("rst_mem_be", {28'h0, bus.mem_be}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      access("lw",  1'b0, 2'b00, 1'b0, 32'h100, 4'h0, 32'h0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1'b0, 2, 1);
      access("lb",  1'b0, 2'b10, 1'b0, 32'h103, 4'h0, 32'h0, 32'h80123456, 0, 32'hFFFFFF80, 1'b0, 2, 1);
      access("lbu", 1'b0, 2'b10, 1'b1, 32'h103, 4'h0, 32'h0, 32'h80123456, 0, 32'h00000080, 1'b0, 2, 1);
      access("lh",  1'b0, 2'b01, 1'b0, 32'h102, 4'h0, 32'h0, 32'h80123456, 1, 32'hFFFF8012, 1'b0, 3, 2);
      access("lhu", 1'b0, 2'b01, 1'b1, 32'h102, 4'h0, 32'h0, 32'h80123456, 0, 32'h00008012, 1'b0, 2, 1);
      access("lb0", 1'b0, 2'b10, 1'b0, 32'h100, 4'h0, 32'h0, 32'h80123456, 0, 32'h00000056, 1'b0, 2, 1);
      access("lh0", 1'b0, 2'b01, 1'b0, 32'h100, 4'h0, 32'h0, 32'h8012F456, 0, 32'hFFFFF456, 1'b0, 2, 1);
      access("sh",  1'b1, 2'b01, 1'b0, 32'h102, 4'b1100, 32'hABCD0000, 32'h12345678, 3, 32'h0, 1'b0, 5, 4);

      bad_access("lw_mis", 1'b0, 2'b00, 32'h101, 4'h0);
      bad_access("sw_be0", 1'b1, 2'b00, 32'h100, 4'h0);
      bad_access("ill_ld", 1'b0, 2'b11, 32'h100, 4'h0);
      bad_access("sh_mis", 1'b1, 2'b01, 32'h103, 4'b1100);

      // Seed rdata, then a timeout must clear it.
      access("lw_seed", 1'b0, 2'b00, 1'b0, 32'h10, 4'h0, 32'h0, 32'h5A5A5A5A, 0, 32'h5A5A5A5A, 1'b0, 2, 1);
      access("tmo", 1'b0, 2'b00, 1'b0, 32'h200, 4'h0, 32'h0, 32'hFFFFFFFF, -1, 32'h0, 1'b1, 1 + TMO, TMO);

      // mem_ready in IDLE must not produce a response.
      bus.mem_ready = 1'b1;
      @(negedge clk);
      #3;
      chk("idle_ready_no_done", {31'h0, bus.done}, 32'h0);
      bus.mem_ready = 1'b0;
      @(negedge clk);

      access("lw_seed2", 1'b0, 2'b00, 1'b0, 32'h20, 4'h0, 32'h0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 1'b0, 2, 1);

      // Reset during BUSY abandons the access.
      bus.req_valid = 1'b1;
      bus.req_we = 1'b0;
      bus.op_width = 2'b00;
      bus.addr = 32'h300;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("pre_rst_busy", {31'h0, bus.mem_req}, 32'h1);
      reset = 1'b1;
      #1;
      chk("midrst_mem_req", {31'h0, bus.mem_req}, 32'h0);
      chk("midrst_stall", {31'h0, bus.stall}, 32'h0);
      chk("midrst_rdata", bus.rdata, 32'h0);
      chk("midrst_mem_addr", {2'b00, bus.mem_addr}, 32'h0);
      chk("midrst_done", {31'h0, bus.done}, 32'h0);
      bus.req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      access("lw_after", 1'b0, 2'b00, 1'b0, 32'h104, 4'h0, 32'h0, 32'h01234567, 0, 32'h01234567, 1'b0, 2, 1);

      @(negedge clk);
      @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
